dispatch_unit_param: RTL and testbench

- Registered, parametrised dispatch stage between decode/rename and the four issue queues (INT, MULT, DIV, LD_ST).
- Accepts one decoded instruction per cycle via valid/ready and holds it in a single-entry dispatch register.
- Tracks per-queue credits so it never overruns a queue, and snoops the CDB so held operands wake up before issue.
- Emits a one-cycle one-hot dispatch pulse plus a shared payload bus.

---
 rtl/dispatch_unit_param_pkg.sv | 80 ++++++++
 rtl/dispatch_unit_param_if.sv | 56 +++++
 rtl/dispatch_credit_ctr.sv | 59 +++++
 rtl/dispatch_unit_param.sv | 174 +++++++++++++++++
 tb/tb_dispatch_unit_param.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_unit_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_unit_param_pkg
// Description : Shared types for the dispatch stage. Includes the RV32 opcode
//               constants, the issue-queue index, the dispatch payload record
//               and the opcode decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_unit_param_pkg;

    // Payload field widths. The XLEN/TAG_W parameters of the dispatch unit
    // must match these values.
    localparam int PKG_XLEN  = 32;
    localparam int PKG_TAG_W = 6;

    localparam logic [6:0] R_TYPE      = 7'b0110011;
    localparam logic [6:0] I_TYPE      = 7'b0010011;
    localparam logic [6:0] LOAD_TYPE   = 7'b0000011;
    localparam logic [6:0] STORE_TYPE  = 7'b0100011;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;
    localparam logic [6:0] J_TYPE      = 7'b1101111;
    localparam logic [6:0] JALR_TYPE   = 7'b1100111;
    localparam logic [6:0] LUI_TYPE    = 7'b0110111;
    localparam logic [6:0] AUIPC_TYPE  = 7'b0010111;

    // Queue index. The enum value is the bit position in disp_en/credit_ret.
    typedef enum logic [1:0] {
        Q_INT  = 2'd0,
        Q_MULT = 2'd1,
        Q_DIV  = 2'd2,
        Q_LDST = 2'd3
    } queue_e;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic [6:0]           func7;
        logic [PKG_XLEN-1:0]  rs1_data;
        logic [PKG_XLEN-1:0]  rs2_data;
        logic [PKG_TAG_W-1:0] rs1_tag;
        logic [PKG_TAG_W-1:0] rs2_tag;
        logic                 rs1_valid;
        logic                 rs2_valid;
        logic [PKG_TAG_W-1:0] rd_tag;
        logic [PKG_XLEN-1:0]  imm;
    } dispatch_payload_t;

    // Target queue for an opcode. Unrecognised opcodes map to Q_INT, but
    // is_legal_op() keeps them from ever being held.
    function automatic queue_e decode_queue(input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7);
        queue_e q;
        q = Q_INT;
        case (op)
            R_TYPE: begin
                if (f7 == 7'd1 && f3 == 3'd0) begin
                    q = Q_MULT;
                end else if (f7 == 7'd1 && f3 == 3'd4) begin
                    q = Q_DIV;
                end
            end
            LOAD_TYPE, STORE_TYPE: q = Q_LDST;
            default:               q = Q_INT;
        endcase
        return q;
    endfunction

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            R_TYPE, I_TYPE, LOAD_TYPE, STORE_TYPE, BRANCH_TYPE,
            J_TYPE, JALR_TYPE, LUI_TYPE, AUIPC_TYPE: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_unit_param_if.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_unit_param_if
// Description : Bundle of decode-side handshake and operands, the CDB snoop
//               bus, credit returns and the dispatch outputs.
//               slave  : the dispatch unit
//               master : the decode/CDB/queue environment
// Revision    : 1.0 - initial release
// ============================================================================
interface dispatch_unit_param_if
    import dispatch_unit_param_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) ();
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_pending;
    logic              rs2_pending;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic [XLEN-1:0]   immediate;
    logic [XLEN-1:0]   jmp_br_addr;
    logic              flush;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_data;
    logic [3:0]        credit_ret;
    logic [3:0]        disp_en;
    dispatch_payload_t out_payload;
    logic              illegal_op;
    logic              credit_err;

    modport slave (
        input  in_valid, opcode, func3, func7, rs1, rs2, rs1_data, rs2_data,
               rs1_pending, rs2_pending, rs1_tag, rs2_tag, rd_tag, immediate,
               jmp_br_addr, flush, cdb_valid, cdb_tag, cdb_data, credit_ret,
        output in_ready, disp_en, out_payload, illegal_op, credit_err
    );

    modport master (
        output in_valid, opcode, func3, func7, rs1, rs2, rs1_data, rs2_data,
               rs1_pending, rs2_pending, rs1_tag, rs2_tag, rd_tag, immediate,
               jmp_br_addr, flush, cdb_valid, cdb_tag, cdb_data, credit_ret,
        input  in_ready, disp_en, out_payload, illegal_op, credit_err
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_credit_ctr
// Description : Free-entry counter for one issue queue. Starts at DEPTH and
//               counts down on dispatch and up on entry release.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               dec_i     - instruction dispatched to this queue
//               inc_i     - queue entry freed
//               zero_o    - no credit available
//               err_o     - sticky: entry freed while counter already full
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_credit_ctr #(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic dec_i,
    input  wire logic inc_i,
    output logic      zero_o,
    output logic      err_o
);
    localparam int               CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // A simultaneous dispatch and release cancel out, even at full. Only a
    // net increase at full is an overflow; it is dropped and flagged.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i) begin
            if (cnt_q == c_full_cnt) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= c_full_cnt;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/dispatch_unit_param.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_unit_param
// Description : Single-entry dispatch register between decode/rename and the
//               INT/MULT/DIV/LD_ST issue queues. It does per-queue credit
//               tracking and CDB operand wake-up, and drives a one-hot
//               dispatch pulse with a shared payload.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus_io    - dispatch_unit_param_if.slave (decode handshake,
//                           operands, CDB, credit returns, dispatch outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_unit_param
    import dispatch_unit_param_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 6,
    parameter int INT_DEPTH  = 4,
    parameter int MULT_DEPTH = 4,
    parameter int DIV_DEPTH  = 4,
    parameter int LDST_DEPTH = 4
) (
    input wire logic               clk,
    input wire logic               rst,
    dispatch_unit_param_if.slave   bus_io
);
    logic              hold_valid_q, hold_valid_d;
    queue_e            sel_q, sel_d;
    dispatch_payload_t hold_q, hold_d;
    dispatch_payload_t last_q, last_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        w_zero;
    logic [3:0]        w_err;
    logic [3:0]        w_disp_en;
    logic              w_fire;
    logic              w_accept;
    logic              w_legal;
    queue_e            w_sel;
    logic              w_rs1_hit, w_rs2_hit;
    logic [XLEN-1:0]   w_rs1_data, w_rs2_data;
    logic              w_rs1_valid, w_rs2_valid;
    dispatch_payload_t w_cap;
    dispatch_payload_t w_snoop;

    assign w_sel   = decode_queue(bus_io.opcode, bus_io.func3, bus_io.func7);
    assign w_legal = is_legal_op(bus_io.opcode);

    assign w_fire          = hold_valid_q & ~w_zero[sel_q] & ~bus_io.flush;
    assign bus_io.in_ready = ~hold_valid_q | w_fire;
    // A flush cycle ignores in_valid even when in_ready is high.
    assign w_accept        = bus_io.in_valid & bus_io.in_ready & ~bus_io.flush;
    assign w_disp_en       = w_fire ? (4'b0001 << sel_q) : 4'b0000;

    // Incoming operands. x0 is always ready and zero. A CDB broadcast in the
    // same cycle as capture takes priority over the stale register-file data.
    always_comb begin
        w_rs1_hit = bus_io.cdb_valid & bus_io.rs1_pending & (bus_io.rs1 != 5'd0)
                    & (bus_io.cdb_tag == bus_io.rs1_tag);
        w_rs2_hit = bus_io.cdb_valid & bus_io.rs2_pending & (bus_io.rs2 != 5'd0)
                    & (bus_io.cdb_tag == bus_io.rs2_tag);

        if (bus_io.rs1 == 5'd0) begin
            w_rs1_data  = '0;
            w_rs1_valid = 1'b1;
        end else if (w_rs1_hit) begin
            w_rs1_data  = bus_io.cdb_data;
            w_rs1_valid = 1'b1;
        end else begin
            w_rs1_data  = bus_io.rs1_data;
            w_rs1_valid = ~bus_io.rs1_pending;
        end

        if (bus_io.rs2 == 5'd0) begin
            w_rs2_data  = '0;
            w_rs2_valid = 1'b1;
        end else if (w_rs2_hit) begin
            w_rs2_data  = bus_io.cdb_data;
            w_rs2_valid = 1'b1;
        end else begin
            w_rs2_data  = bus_io.rs2_data;
            w_rs2_valid = ~bus_io.rs2_pending;
        end

        // ALU-immediate ops carry the immediate as the second operand.
        // Loads have no rs2 dependency.
        if (bus_io.opcode == I_TYPE) begin
            w_rs2_data  = bus_io.immediate;
            w_rs2_valid = 1'b1;
        end else if (bus_io.opcode == LOAD_TYPE) begin
            w_rs2_valid = 1'b1;
        end

        w_cap.opcode    = bus_io.opcode;
        w_cap.func3     = bus_io.func3;
        w_cap.func7     = bus_io.func7;
        w_cap.rs1_data  = w_rs1_data;
        w_cap.rs2_data  = w_rs2_data;
        w_cap.rs1_tag   = bus_io.rs1_tag;
        w_cap.rs2_tag   = bus_io.rs2_tag;
        w_cap.rs1_valid = w_rs1_valid;
        w_cap.rs2_valid = w_rs2_valid;
        w_cap.rd_tag    = bus_io.rd_tag;
        w_cap.imm       = (w_sel == Q_LDST) ? bus_io.jmp_br_addr : bus_io.immediate;
    end

    // Held-entry wake-up. The same view feeds the payload bus so that a
    // broadcast arriving in the fire cycle is not lost.
    always_comb begin
        w_snoop = hold_q;
        if (!hold_q.rs1_valid && bus_io.cdb_valid && bus_io.cdb_tag == hold_q.rs1_tag) begin
            w_snoop.rs1_data  = bus_io.cdb_data;
            w_snoop.rs1_valid = 1'b1;
        end
        if (!hold_q.rs2_valid && bus_io.cdb_valid && bus_io.cdb_tag == hold_q.rs2_tag) begin
            w_snoop.rs2_data  = bus_io.cdb_data;
            w_snoop.rs2_valid = 1'b1;
        end
    end

    always_comb begin
        hold_d = w_accept ? w_cap : w_snoop;
        sel_d  = w_accept ? w_sel : sel_q;
        last_d = w_fire ? w_snoop : last_q;
        // Illegal opcodes are consumed but never occupy the register.
        illegal_d = w_accept & ~w_legal;
        if (w_accept && w_legal) begin
            hold_valid_d = 1'b1;
        end else if (w_fire || bus_io.flush) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            sel_q        <= Q_INT;
            hold_q       <= '0;
            last_q       <= '0;
            illegal_q    <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            sel_q        <= sel_d;
            hold_q       <= hold_d;
            last_q       <= last_d;
            illegal_q    <= illegal_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_credit
        localparam int c_depth = (g == 0) ? INT_DEPTH  :
                                 (g == 1) ? MULT_DEPTH :
                                 (g == 2) ? DIV_DEPTH  : LDST_DEPTH;
        dispatch_credit_ctr #(
            .DEPTH (c_depth)
        ) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .dec_i  (w_disp_en[g]),
            .inc_i  (bus_io.credit_ret[g]),
            .zero_o (w_zero[g]),
            .err_o  (w_err[g])
        );
    end

    assign bus_io.disp_en     = w_disp_en;
    assign bus_io.out_payload = w_fire ? w_snoop : last_q;
    assign bus_io.illegal_op  = illegal_q;
    assign bus_io.credit_err  = |w_err;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_unit_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_unit_param
// Description : Directed self-checking bench for dispatch_unit_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_unit_param;
    import dispatch_unit_param_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dispatch_unit_param_if #(.XLEN(32), .TAG_W(6)) bus ();

    dispatch_unit_param #(
        .XLEN(32), .TAG_W(6), .INT_DEPTH(4), .MULT_DEPTH(4),
        .DIV_DEPTH(4), .LDST_DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] r1, input logic [4:0] r2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic p1, input logic p2,
                             input logic [5:0] t1, input logic [5:0] t2, input logic [5:0] rd,
                             input logic [31:0] imm, input logic [31:0] addr);
        bus.opcode = op;  bus.func3 = f3;  bus.func7 = f7;
        bus.rs1 = r1;  bus.rs2 = r2;  bus.rs1_data = d1;  bus.rs2_data = d2;
        bus.rs1_pending = p1;  bus.rs2_pending = p2;
        bus.rs1_tag = t1;  bus.rs2_tag = t2;  bus.rd_tag = rd;
        bus.immediate = imm;  bus.jmp_br_addr = addr;
    endtask

    task automatic clear_inputs;
        set_instr(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0,
                  6'd0, 6'd0, 6'd0, 32'd0, 32'd0);
        bus.in_valid = 1'b0;  bus.flush = 1'b0;
        bus.cdb_valid = 1'b0;  bus.cdb_tag = 6'd0;  bus.cdb_data = 32'd0;
        bus.credit_ret = 4'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step;
        rst = 1'b0;
        sample;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_tests++; if (bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL reset_disp_en: got %b want 0000", bus.disp_en); end
        n_tests++; if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_op); end
        n_tests++; if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b want 0", bus.credit_err); end
        n_tests++; if (bus.out_payload !== '0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", bus.out_payload); end
    endtask

    task automatic test_add;
        step;
        set_instr(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 32'h11, 32'h22, 1'b0, 1'b0,
                  6'd1, 6'd2, 6'd3, 32'h5, 32'h0);
        bus.in_valid = 1'b1;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL add_no_early_pulse: got %b want 0000", bus.disp_en); end
        step;
        bus.in_valid = 1'b0;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0001) begin n_fail++; $display("FAIL add_disp_en: got %b want 0001", bus.disp_en); end
        n_tests++;
        if (bus.out_payload.rs1_valid !== 1'b1 || bus.out_payload.rs2_valid !== 1'b1 ||
            bus.out_payload.rs1_data !== 32'h11 || bus.out_payload.rs2_data !== 32'h22 ||
            bus.out_payload.rd_tag !== 6'd3 || bus.out_payload.imm !== 32'h5) begin
            n_fail++; $display("FAIL add_payload: got %h want rs1=11 rs2=22 both valid rd=3 imm=5", bus.out_payload);
        end
        step;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL add_single_pulse: got %b want 0000", bus.disp_en); end
        n_tests++; if (bus.out_payload.rs1_data !== 32'h11) begin n_fail++; $display("FAIL add_payload_hold: got %h want 11", bus.out_payload.rs1_data); end
    endtask

    task automatic test_mul_cdb;
        step;
        set_instr(R_TYPE, 3'd0, 7'd1, 5'd3, 5'd4, 32'h999, 32'h7, 1'b1, 1'b0,
                  6'h05, 6'h06, 6'h07, 32'h0, 32'h0);
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        bus.cdb_valid = 1'b1;  bus.cdb_tag = 6'h05;  bus.cdb_data = 32'hDEAD_BEEF;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0010) begin n_fail++; $display("FAIL mul_disp_en: got %b want 0010", bus.disp_en); end
        n_tests++;
        if (bus.out_payload.rs1_data !== 32'hDEAD_BEEF || bus.out_payload.rs1_valid !== 1'b1 ||
            bus.out_payload.rs2_data !== 32'h7) begin
            n_fail++; $display("FAIL mul_cdb_forward: got rs1=%h v=%b rs2=%h want rs1=deadbeef v=1 rs2=7",
                               bus.out_payload.rs1_data, bus.out_payload.rs1_valid, bus.out_payload.rs2_data);
        end
        step;
        bus.cdb_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            set_instr(R_TYPE, 3'd4, 7'd1, 5'd5, 5'd6, 32'h100 + i, 32'h3, 1'b0, 1'b0,
                      6'd0, 6'd0, 6'd8, 32'h0, 32'h0);
            bus.in_valid = 1'b1;
            sample;
            n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL div_in_ready_%0d: got %b want 1", i, bus.in_ready); end
            if (i > 0) begin
                n_tests++;
                if (bus.disp_en !== 4'b0100 || bus.out_payload.rs1_data !== 32'h100 + i - 1) begin
                    n_fail++; $display("FAIL div_pulse_%0d: got en=%b rs1=%h want en=0100 rs1=%h",
                                       i, bus.disp_en, bus.out_payload.rs1_data, 32'h100 + i - 1);
                end
            end
            step;
        end
        bus.in_valid = 1'b0;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL div_stall: got en=%b rdy=%b want en=0000 rdy=0", bus.disp_en, bus.in_ready); end
        step;
        bus.credit_ret = 4'b0100;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL div_ret_cycle: got %b want 0000", bus.disp_en); end
        step;
        bus.credit_ret = 4'b0000;
        sample;
        n_tests++;
        if (bus.disp_en !== 4'b0100 || bus.out_payload.rs1_data !== 32'h104) begin
            n_fail++; $display("FAIL div_resume: got en=%b rs1=%h want en=0100 rs1=104", bus.disp_en, bus.out_payload.rs1_data);
        end
        step;
    endtask

    task automatic test_load;
        set_instr(LOAD_TYPE, 3'd2, 7'd0, 5'd2, 5'd0, 32'h2000, 32'h0, 1'b1, 1'b0,
                  6'd9, 6'd0, 6'd10, 32'h40, 32'h1000_0040);
        bus.in_valid = 1'b1;
        bus.cdb_valid = 1'b1;  bus.cdb_tag = 6'd9;  bus.cdb_data = 32'hABC0;
        step;
        bus.in_valid = 1'b0;  bus.cdb_valid = 1'b0;
        bus.credit_ret = 4'b1000;
        sample;
        n_tests++; if (bus.disp_en !== 4'b1000) begin n_fail++; $display("FAIL lw_disp_en: got %b want 1000", bus.disp_en); end
        n_tests++;
        if (bus.out_payload.imm !== 32'h1000_0040 || bus.out_payload.rs2_valid !== 1'b1) begin
            n_fail++; $display("FAIL lw_imm_rs2v: got imm=%h v=%b want imm=10000040 v=1", bus.out_payload.imm, bus.out_payload.rs2_valid);
        end
        n_tests++;
        if (bus.out_payload.rs1_data !== 32'hABC0 || bus.out_payload.rs1_valid !== 1'b1) begin
            n_fail++; $display("FAIL lw_capture_cdb: got rs1=%h v=%b want rs1=abc0 v=1", bus.out_payload.rs1_data, bus.out_payload.rs1_valid);
        end
        step;
        bus.credit_ret = 4'b0000;
        // LD_ST counter must still hold 4: four stores then go out back to back.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_instr(STORE_TYPE, 3'd2, 7'd0, 5'd6, 5'd7, 32'h0 + i, 32'h70 + i, 1'b0, 1'b0,
                          6'd0, 6'd0, 6'd0, 32'h8, 32'h2000_0000 + i);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            sample;
            if (i == 0) begin
                n_tests++; if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL lw_same_cycle_err: got %b want 0", bus.credit_err); end
            end else begin
                n_tests++;
                if (bus.disp_en !== 4'b1000 || bus.out_payload.imm !== 32'h2000_0000 + i - 1) begin
                    n_fail++; $display("FAIL sw_pulse_%0d: got en=%b imm=%h want en=1000 imm=%h",
                                       i, bus.disp_en, bus.out_payload.imm, 32'h2000_0000 + i - 1);
                end
            end
            step;
        end
    endtask

    task automatic test_illegal;
        set_instr(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0,
                  6'd0, 6'd0, 6'd0, 32'h0, 32'h0);
        bus.in_valid = 1'b1;
        sample;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_accept: got %b want 1", bus.in_ready); end
        step;
        bus.in_valid = 1'b0;
        sample;
        n_tests++;
        if (bus.illegal_op !== 1'b1 || bus.disp_en !== 4'b0000 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ill_pulse: got ill=%b en=%b rdy=%b want ill=1 en=0000 rdy=1", bus.illegal_op, bus.disp_en, bus.in_ready);
        end
        step;
        sample;
        n_tests++;
        if (bus.illegal_op !== 1'b0 || bus.disp_en !== 4'b0000) begin
            n_fail++; $display("FAIL ill_one_shot: got ill=%b en=%b want ill=0 en=0000", bus.illegal_op, bus.disp_en);
        end
        step;
    endtask

    task automatic test_flush;
        // MULT has 3 credits left; the fourth MUL ends up held at zero credits.
        for (int i = 0; i < 4; i++) begin
            set_instr(R_TYPE, 3'd0, 7'd1, 5'd1, 5'd2, 32'h0 + i, 32'h1, 1'b0, 1'b0,
                      6'd0, 6'd0, 6'd0, 32'h0, 32'h0);
            bus.in_valid = 1'b1;
            sample;
            if (i > 0) begin
                n_tests++; if (bus.disp_en !== 4'b0010) begin n_fail++; $display("FAIL mul_drain_%0d: got %b want 0010", i, bus.disp_en); end
            end
            step;
        end
        bus.in_valid = 1'b0;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_held: got en=%b rdy=%b want en=0000 rdy=0", bus.disp_en, bus.in_ready); end
        step;
        bus.flush = 1'b1;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL flush_no_pulse: got %b want 0000", bus.disp_en); end
        step;
        bus.flush = 1'b0;
        sample;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cleared: got rdy=%b want 1", bus.in_ready); end
        step;
        bus.credit_ret = 4'b0010;
        step;
        bus.credit_ret = 4'b0000;
        sample;
        n_tests++; if (bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL flush_dropped: got %b want 0000", bus.disp_en); end
        step;
    endtask

    task automatic test_credit_err_and_reset;
        // INT is at 3 after the ADD: the first return is legal, the second overflows.
        bus.credit_ret = 4'b0001;
        step;
        bus.credit_ret = 4'b0000;
        sample;
        n_tests++; if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL cerr_legal_ret: got %b want 0", bus.credit_err); end
        step;
        bus.credit_ret = 4'b0001;
        step;
        bus.credit_ret = 4'b0000;
        sample;
        n_tests++; if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL cerr_set: got %b want 1", bus.credit_err); end
        repeat (2) step;
        sample;
        n_tests++; if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL cerr_sticky: got %b want 1", bus.credit_err); end
        // LD_ST is out of credits, so this store stays held until reset.
        step;
        set_instr(STORE_TYPE, 3'd2, 7'd0, 5'd6, 5'd7, 32'h1, 32'h2, 1'b0, 1'b0,
                  6'd0, 6'd0, 6'd0, 32'h0, 32'h4444_0000);
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        sample;
        n_tests++; if (bus.in_ready !== 1'b0 || bus.disp_en !== 4'b0000) begin n_fail++; $display("FAIL sw_held: got rdy=%b en=%b want rdy=0 en=0000", bus.in_ready, bus.disp_en); end
        step;
        rst = 1'b1;
        repeat (2) step;
        rst = 1'b0;
        sample;
        n_tests++;
        if (bus.credit_err !== 1'b0 || bus.in_ready !== 1'b1 || bus.disp_en !== 4'b0000 || bus.out_payload !== '0) begin
            n_fail++; $display("FAIL rst_mid_hold: got err=%b rdy=%b en=%b pay=%h want err=0 rdy=1 en=0000 pay=0",
                               bus.credit_err, bus.in_ready, bus.disp_en, bus.out_payload);
        end
        step;
        set_instr(LOAD_TYPE, 3'd2, 7'd0, 5'd1, 5'd0, 32'h5, 32'h0, 1'b0, 1'b0,
                  6'd0, 6'd0, 6'd0, 32'h0, 32'h3000_0000);
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        sample;
        n_tests++;
        if (bus.disp_en !== 4'b1000 || bus.out_payload.imm !== 32'h3000_0000) begin
            n_fail++; $display("FAIL rst_credits_restored: got en=%b imm=%h want en=1000 imm=30000000", bus.disp_en, bus.out_payload.imm);
        end
        step;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear_inputs;
        test_reset;
        test_add;
        test_mul_cdb;
        test_back_to_back;
        test_load;
        test_illegal;
        test_flush;
        test_credit_err_and_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
